// File: rtl/fifo_wptr_full_pkg.sv
// Shared dual-clock FIFO definitions: pointer width helper, Gray/binary
// conversion pair and the default synchroniser depth.
package fifo_wptr_full_pkg;

    localparam int PTR_WORD_W = 32;
    localparam int FIFO_SYNC_STAGES_DEFAULT = 2;

    typedef logic [PTR_WORD_W-1:0] ptr_word_t;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    // Both conversions work on a zero-extended word; callers size-cast the result.
    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_WORD_W-1] = g[PTR_WORD_W-1];
        for (int i = PTR_WORD_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_ptr_sync.sv
// Multi-bit flop chain used to bring a Gray pointer across a clock domain.
module ptr_sync
    import fifo_wptr_full_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = FIFO_SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer / full-flag controller of the dual-clock FIFO.
// Define FIFO_ALMOST_FULL_EN to add the registered almost_full output.
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES_DEFAULT,
    parameter int AF_MARGIN   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W:0]       rptr_gray_async,
    output logic [ADDR_W-1:0]     waddr,
    output logic                  wr_accept,
    output logic [ADDR_W:0]       wptr_gray,
    output logic                  full,
    output logic                  overflow
`ifdef FIFO_ALMOST_FULL_EN
   ,output logic                  almost_full
`endif
);

    localparam int PW = ptr_w(ADDR_W);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("fifo_wptr_full: SYNC_STAGES must be 2 or 3");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > (1 << ADDR_W) - 1) begin : g_bad_margin
        $error("fifo_wptr_full: AF_MARGIN out of range");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rq;
    logic [PW-1:0] full_pattern;

    ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (rptr_gray_async),
        .q   (rq)
    );

    assign wr_accept  = wr_en & ~full;
    assign wbin_next  = wbin + PW'(wr_accept);
    assign wgray_next = PW'(bin2gray(ptr_word_t'(wbin_next)));
    assign waddr      = wbin[ADDR_W-1:0];

    // Writer is exactly one lap ahead: top two Gray bits flipped, rest equal.
    assign full_pattern = {~rq[PW-1:PW-2], rq[PW-3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin      <= '0;
            wptr_gray <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wbin      <= wbin_next;
            wptr_gray <= wgray_next;
            full      <= (wgray_next == full_pattern);
            overflow  <= overflow | (wr_en & full);
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_THRESH = PW'((1 << ADDR_W) - AF_MARGIN);

    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] fill;

    assign rbin_sync = PW'(gray2bin(ptr_word_t'(rq)));
    assign fill      = wbin_next - rbin_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (fill >= AF_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_W=4, SYNC_STAGES=2, default build).
module tb_fifo_wptr_full;

    localparam int ADDR_W = 4;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 16;
    localparam int PMOD   = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [4:0] rptr_gray_async;
    logic [3:0] waddr;
    logic       wr_accept;
    logic [4:0] wptr_gray;
    logic       full;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: counts of entries written / read, plus the read counts
    // the writer has not yet been able to see through the synchroniser.
    int wcount;
    int rptr;
    bit full_m;
    bit ovf_m;
    int hist[$];

    always #5 clk = ~clk;

    fifo_wptr_full #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC),
        .AF_MARGIN   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .rptr_gray_async (rptr_gray_async),
        .waddr           (waddr),
        .wr_accept       (wr_accept),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .overflow        (overflow)
    );

    function automatic logic [4:0] toGray(input int b);
        logic [4:0] v;
        v = 5'(b & (PMOD - 1));
        return v ^ (v >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        wcount = 0;
        rptr   = 0;
        full_m = 0;
        ovf_m  = 0;
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(0);
    endtask

    // One clock cycle: drive inputs, check the combinational accept, clock,
    // advance the model and compare all registered outputs.
    task automatic applyStimulus(input bit wr, output bit acc);
        int rseen;
        int fill;
        @(negedge clk);
        wr_en           = wr;
        rptr_gray_async = toGray(rptr);
        #1;
        acc = wr && !full_m;
        checkOutput("wr_accept", 32'(wr_accept), 32'(acc));
        @(posedge clk);
        rseen = hist.pop_front();
        hist.push_back(rptr);
        if (wr && full_m) ovf_m = 1;
        if (acc) wcount++;
        fill   = (wcount - rseen) & (PMOD - 1);
        full_m = (fill == DEPTH);
        #1;
        checkOutput("waddr", 32'(waddr), 32'(wcount % DEPTH));
        checkOutput("wptr_gray", 32'(wptr_gray), 32'(toGray(wcount)));
        checkOutput("full", 32'(full), 32'(full_m));
        checkOutput("overflow", 32'(overflow), 32'(ovf_m));
    endtask

    // Asynchronous reset pulsed in the middle of a cycle.
    task automatic applyReset();
        @(negedge clk);
        #2;
        wr_en = 1'b1;
        rst   = 1'b1;
        #1;
        checkOutput("rst_waddr", 32'(waddr), 0);
        checkOutput("rst_wptr_gray", 32'(wptr_gray), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_wr_accept", 32'(wr_accept), 1);
        wr_en           = 1'b0;
        rptr_gray_async = '0;
        resetModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit acc;
        int cnt;
        logic [4:0] prev_gray;
        logic [3:0] held_addr;

        rst             = 1'b1;
        wr_en           = 1'b0;
        rptr_gray_async = '0;
        #1;
        checkOutput("init_full", 32'(full), 0);
        checkOutput("init_waddr", 32'(waddr), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resetModel();

        // A few writes so the mid-stream reset has something to clear.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, acc);
        applyReset();

        // Fill with the reader parked at zero.
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1'b1, acc);
            checkOutput("fill_accept", 32'(acc), 32'(i <= 16));
            checkOutput("fill_full_flag", 32'(full), 32'(i >= 16));
            checkOutput("fill_overflow_flag", 32'(overflow), 32'(i >= 17));
        end

        // Reader frees three slots; full releases three edges later.
        rptr = 3;
        cnt  = 0;
        for (int j = 1; j <= 6; j++) begin
            applyStimulus(1'b1, acc);
            if (acc) cnt++;
            checkOutput("drain_full_flag", 32'(full), 32'(j <= 2 || j == 6));
        end
        checkOutput("drain_accepts", 32'(cnt), 3);

        // Read pointer advances in the same cycle a write hits a full FIFO.
        held_addr = waddr;
        rptr      = 4;
        applyStimulus(1'b1, acc);
        checkOutput("simul_refused", 32'(acc), 0);
        checkOutput("simul_waddr", 32'(waddr), 32'(held_addr));
        checkOutput("simul_waddr_abs", 32'(waddr), 3);

        // Long stream across the 31->0 pointer wrap, reader trailing by 8.
        applyReset();
        for (int i = 0; i < 40; i++) begin
            rptr      = (wcount > 8) ? wcount - 8 : 0;
            prev_gray = wptr_gray;
            applyStimulus(1'b1, acc);
            checkOutput("wrap_onebit", 32'($countones(prev_gray ^ wptr_gray)), 32'(acc ? 1 : 0));
            checkOutput("wrap_no_full", 32'(full), 0);
        end
        checkOutput("wrap_final_waddr", 32'(waddr), 8);
        checkOutput("wrap_final_gray", 32'(wptr_gray), 32'(5'b01100));

        // Random traffic with a mid-stream reset.
        applyReset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) applyReset();
            if ($urandom_range(0, 2) == 0 && rptr < wcount) rptr++;
            prev_gray = wptr_gray;
            applyStimulus($urandom_range(0, 3) != 0, acc);
            checkOutput("rand_onebit", 32'($countones(prev_gray ^ wptr_gray)), 32'(acc ? 1 : 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
